// File: rtl/div_clk_tick_receiver.sv
// Receives a slow divided clock level, emits divided single-cycle ticks and flags a stalled source.
// Optional feature macro STALL_AUTO_RECOVER_EN: an edge alone may leave STALLED.
module div_clk_tick_receiver #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 120000000,
  parameter int unsigned WD_W           = 27
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        divided_clk,
  input  logic [1:0]  edge_sel,
  input  logic [3:0]  tick_div,
  input  logic        clear_stall,
  output logic        tick,
  output logic [15:0] tick_count,
  output logic        stalled
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_STALLED = 2'd2
  } state_e;

  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   s;
  logic                   rise;
  logic                   fall;
  logic                   any_edge;
  logic                   qual;
  logic                   timeout;

  state_e          state_q;
  state_e          state_d;
  logic [3:0]      div_cnt_q;
  logic [3:0]      div_cnt_d;
  logic [3:0]      div_base;
  logic [WD_W-1:0] wd_q;
  logic [WD_W-1:0] wd_d;
  logic [15:0]     tick_count_q;
  logic [15:0]     tick_count_d;
  logic            tick_q;
  logic            tick_d;
  logic            stalled_q;
  logic            stalled_d;
  logic            process_edge;

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], divided_clk};
      prev_q <= s;
    end
  end

  always_comb begin
    s        = sync_q[SYNC_STAGES-1];
    rise     = s & ~prev_q;
    fall     = ~s & prev_q;
    any_edge = rise | fall;
    qual     = (edge_sel[0] & rise) | (edge_sel[1] & fall);
    timeout  = ~any_edge & (wd_q == WD_LAST);
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_RUN: begin
        if (any_edge) begin
          state_d = ST_RUN;
        end else if (timeout) begin
          state_d = ST_STALLED;
        end
      end
      ST_STALLED: begin
        if (clear_stall) begin
          state_d = ST_IDLE;
`ifdef STALL_AUTO_RECOVER_EN
        end else if (any_edge) begin
          state_d = ST_RUN;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // IDLE and RUN share edge handling; the IDLE->RUN edge is itself a counted edge
  always_comb begin
    div_cnt_d    = div_cnt_q;
    div_base     = div_cnt_q;
    wd_d         = wd_q;
    tick_count_d = tick_count_q;
    tick_d       = 1'b0;
    process_edge = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_RUN: begin
        process_edge = 1'b1;
        if (any_edge || timeout) begin
          wd_d = '0;
        end else begin
          wd_d = wd_q + WD_ONE;
        end
      end
      ST_STALLED: begin
        wd_d = '0;
        if (clear_stall) begin
          div_cnt_d = '0;
`ifdef STALL_AUTO_RECOVER_EN
        end else if (any_edge) begin
          div_cnt_d    = '0;
          div_base     = '0;
          process_edge = 1'b1;
`endif
        end
      end
      default: begin
        wd_d = '0;
      end
    endcase

    if (process_edge && qual) begin
      if (div_base >= tick_div) begin
        div_cnt_d    = '0;
        tick_d       = 1'b1;
        tick_count_d = tick_count_q + 16'd1;
      end else begin
        div_cnt_d = div_base + 4'd1;
      end
    end

    stalled_d = (state_d == ST_STALLED);
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      div_cnt_q    <= '0;
      wd_q         <= '0;
      tick_count_q <= '0;
      tick_q       <= 1'b0;
      stalled_q    <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      wd_q         <= wd_d;
      tick_count_q <= tick_count_d;
      tick_q       <= tick_d;
      stalled_q    <= stalled_d;
    end
  end

  assign tick       = tick_q;
  assign tick_count = tick_count_q;
  assign stalled    = stalled_q;

endmodule

// File: tb/tb_div_clk_tick_receiver.sv
// Bench for div_clk_tick_receiver: directed and random stimulus checked every cycle
// against a time-stamp based reference model.
module tb_div_clk_tick_receiver;

  localparam int unsigned SYNC = 2;
  localparam int unsigned TO   = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        dclk;
  logic [1:0]  es;
  logic [3:0]  td;
  logic        clr;
  logic        tick;
  logic [15:0] tcnt;
  logic        stalled;

  always #5 clk = ~clk;

  div_clk_tick_receiver #(
    .SYNC_STAGES   (SYNC),
    .TIMEOUT_CYCLES(TO),
    .WD_W          (27)
  ) dut (
    .clk_in     (clk),
    .rst        (rst),
    .divided_clk(dclk),
    .edge_sel   (es),
    .tick_div   (td),
    .clear_stall(clr),
    .tick       (tick),
    .tick_count (tcnt),
    .stalled    (stalled)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: sampled-level history, "cycles since last activity" watchdog,
  // and a count of qualifying edges since the last tick.
  bit          hist[$];
  int          mode;      // 0 idle, 1 run, 2 stalled
  int          cyc = 0;
  int          last_ev = 0;
  int          cnt = 0;
  logic        m_tick = 1'b0;
  logic [15:0] m_count = '0;
  logic        m_stalled = 1'b0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic count_edge();
    if (cnt >= int'(td)) begin
      cnt     = 0;
      m_tick  = 1'b1;
      m_count = m_count + 16'd1;
    end else begin
      cnt = cnt + 1;
    end
  endtask

  task automatic step();
    bit rise, fall, ev, q;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      hist.delete();
      for (int unsigned i = 0; i < SYNC + 2; i++) hist.push_back(1'b0);
      mode      = 0;
      last_ev   = cyc;
      cnt       = 0;
      m_tick    = 1'b0;
      m_count   = '0;
      m_stalled = 1'b0;
    end else begin
      hist.push_back(dclk);
      void'(hist.pop_front());
      rise   = hist[1] && !hist[0];
      fall   = !hist[1] && hist[0];
      ev     = rise || fall;
      q      = (es[0] && rise) || (es[1] && fall);
      m_tick = 1'b0;
      if (mode != 2) begin
        if (ev) begin
          mode    = 1;
          last_ev = cyc;
          if (q) count_edge();
        end else if (cyc - last_ev == int'(TO)) begin
          mode = 2;
        end
      end else begin
        last_ev = cyc;
        if (clr) begin
          mode = 0;
          cnt  = 0;
`ifdef STALL_AUTO_RECOVER_EN
        end else if (ev) begin
          mode = 1;
          cnt  = 0;
          if (q) count_edge();
`endif
        end
      end
      m_stalled = (mode == 2);
    end
    #1;
    check("tick", 16'(tick), 16'(m_tick));
    check("tick_count", tcnt, m_count);
    check("stalled", 16'(stalled), 16'(m_stalled));
  endtask

  task automatic toggle(input int unsigned n);
    dclk = ~dclk;
    repeat (n) step();
  endtask

  initial begin
    int unsigned gap;
    logic [15:0] base;

    rst  = 1'b0;
    dclk = 1'b0;
    es   = 2'b01;
    td   = 4'd0;
    clr  = 1'b0;

    // reset with the slow clock toggling
    repeat (4) begin
      dclk = ~dclk;
      step();
      check("rst_tick", 16'(tick), 16'd0);
      check("rst_stalled", 16'(stalled), 16'd0);
    end
    rst  = 1'b1;
    dclk = 1'b0;
    repeat (3) begin
      step();
      check("post_rst_tick", 16'(tick), 16'd0);
      check("post_rst_cnt", tcnt, 16'd0);
    end

    // default ratio, rising edges, period 20
    for (int unsigned p = 0; p < 10; p++) begin
      dclk = 1'b1;
      step();
      step();
      check("lat_early", 16'(tick), 16'd0);
      step();
      check("lat3", 16'(tick), 16'd1);
      repeat (7) step();
      dclk = 1'b0;
      repeat (10) step();
    end
    check("ten_ticks", tcnt, 16'd10);

    // division by 4 on both edges, then shrink the ratio mid-count
    es = 2'b11;
    td = 4'd3;
    repeat (12) toggle(5);
    check("div4", tcnt, 16'd13);
    repeat (3) toggle(5);
    check("div4_pend", tcnt, 16'd13);
    td = 4'd1;
    toggle(5);
    check("shrink_fire", tcnt, 16'd14);
    repeat (4) toggle(5);
    check("div2", tcnt, 16'd16);

    // random ratios, edge selects, gaps and clears
    for (int unsigned i = 0; i < 150; i++) begin
      es  = 2'($urandom_range(0, 3));
      td  = 4'($urandom_range(0, 5));
      gap = $urandom_range(1, 24);
      dclk = ~dclk;
      for (int unsigned k = 0; k < gap; k++) begin
        clr = ($urandom_range(0, 7) == 0);
        step();
      end
    end

    // reset landing on the edge that would tick
    es  = 2'b11;
    td  = 4'd0;
    clr = 1'b1;
    repeat (4) step();
    clr = 1'b0;
    toggle(2);
    rst  = 1'b0;
    dclk = 1'b0;
    step();
    rst = 1'b1;
    check("rst_mid_tick", 16'(tick), 16'd0);
    check("rst_mid_cnt", tcnt, 16'd0);

    // watchdog: edge on the last count wins, then a real stall
    es = 2'b01;
    toggle(3);
    check("wd_first_tick", 16'(tick), 16'd1);
    repeat (17) step();
    toggle(3);
    check("wd_edge_wins", 16'(stalled), 16'd0);
    repeat (19) step();
    check("wd_pre_stall", 16'(stalled), 16'd0);
    step();
    check("wd_stall", 16'(stalled), 16'd1);

`ifdef STALL_AUTO_RECOVER_EN
    es = 2'b11;
    toggle(3);
    check("auto_unstall", 16'(stalled), 16'd0);
    check("auto_tick", 16'(tick), 16'd1);
`else
    base = m_count;
    toggle(5);
    toggle(5);
    check("stall_hold", 16'(stalled), 16'd1);
    check("stall_no_tick", tcnt, base);
`endif
    repeat (22) step();
    check("restall", 16'(stalled), 16'd1);

    // recovery via clear_stall, divider restarts from zero
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clear", 16'(stalled), 16'd0);
    es   = 2'b11;
    td   = 4'd1;
    base = m_count;
    toggle(5);
    check("rec_first", tcnt, base);
    toggle(5);
    check("rec_tick", tcnt, base + 16'd1);

    // tick_count wrap after 65536 ticks
    es   = 2'b11;
    td   = 4'd0;
    rst  = 1'b0;
    dclk = 1'b0;
    step();
    rst = 1'b1;
    repeat (100) toggle(1);
    repeat (4) step();
    check("wrap_mid", tcnt, 16'd100);
    repeat (65436) toggle(1);
    repeat (4) step();
    check("wrap", tcnt, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
